// File: rtl/rr_merge_pipe.sv
// rr_merge_pipe: two buffered inputs
// merged onto one enq port by an arbiter
module rr_merge_pipe #(
  parameter int unsigned DEPTH  = 2,
  parameter bit          STRICT = 1'b0
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         a_enq__ENA,
  input  logic [127:0] a_enq_v,
  output logic         a_enq__RDY,
  input  logic         b_enq__ENA,
  input  logic [127:0] b_enq_v,
  output logic         b_enq__RDY,
  output logic         out_enq__ENA,
  output logic [127:0] out_enq_v,
  input  logic         out_enq__RDY,
  output logic         grant_b
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [127:0]  mem_a_q [DEPTH];
  logic [127:0]  mem_b_q [DEPTH];
  logic [AW-1:0] rp_a_q, rp_a_d, wp_a_q, wp_a_d;
  logic [AW-1:0] rp_b_q, rp_b_d, wp_b_q, wp_b_d;
  logic [CW-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic          prio_b_q, prio_b_d;

  logic req_a, req_b, win_b, xfer;
  logic enq_a, enq_b, deq_a, deq_b;

  always_comb begin
    req_a = (cnt_a_q != '0);
    req_b = (cnt_b_q != '0);
    win_b = req_b & (~req_a | STRICT | prio_b_q);
    xfer  = out_enq__RDY & (req_a | req_b);
    deq_a = xfer & ~win_b;
    deq_b = xfer & win_b;
    enq_a = a_enq__ENA & a_enq__RDY;
    enq_b = b_enq__ENA & b_enq__RDY;

    rp_a_d  = rp_a_q + AW'(deq_a);
    wp_a_d  = wp_a_q + AW'(enq_a);
    cnt_a_d = cnt_a_q + CW'(enq_a) - CW'(deq_a);
    rp_b_d  = rp_b_q + AW'(deq_b);
    wp_b_d  = wp_b_q + AW'(enq_b);
    cnt_b_d = cnt_b_q + CW'(enq_b) - CW'(deq_b);

    prio_b_d = prio_b_q;
    if (xfer && !STRICT) prio_b_d = ~win_b;
  end

  always_comb begin
    a_enq__RDY   = nRST & (cnt_a_q != FULL);
    b_enq__RDY   = nRST & (cnt_b_q != FULL);
    out_enq__ENA = xfer;
    grant_b      = xfer & win_b;
    out_enq_v    = '0;
    if (xfer) out_enq_v = win_b ? mem_b_q[rp_b_q] : mem_a_q[rp_a_q];
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rp_a_q   <= '0;
      wp_a_q   <= '0;
      cnt_a_q  <= '0;
      rp_b_q   <= '0;
      wp_b_q   <= '0;
      cnt_b_q  <= '0;
      prio_b_q <= 1'b0;
    end else begin
      rp_a_q   <= rp_a_d;
      wp_a_q   <= wp_a_d;
      cnt_a_q  <= cnt_a_d;
      rp_b_q   <= rp_b_d;
      wp_b_q   <= wp_b_d;
      cnt_b_q  <= cnt_b_d;
      prio_b_q <= prio_b_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (enq_a) mem_a_q[wp_a_q] <= a_enq_v;
    if (enq_b) mem_b_q[wp_b_q] <= b_enq_v;
  end

endmodule

// File: doc/rr_merge_pipe.md
# rr_merge_pipe

Two-input merge controller that shares one 128-bit `out$enq` port between requesters `a` and `b`. Each input is buffered in its own DEPTH-entry FIFO, and a round-robin arbiter picks one non-empty FIFO per cycle to drain into the shared downstream consumer. It sits in front of any single-consumer enq port in the echo datapath, for example the merge of request and forward traffic. It replaces ad-hoc fixed-priority muxing with fair, starvation-free scheduling.

## Interface
Parameters:
- DEPTH, 2, entries per input FIFO; power of two, ≥2
- STRICT, 0, 1 = fixed priority (`b` always wins), 0 = round-robin

Ports:
- CLK  input  1  clock; all state on rising edge
- nRST  input  1  asynchronous, active-low reset
- a$enq__ENA  input  1  enqueue to input `a`; asserted only while a$enq__RDY=1
- a$enq$v  input  128  data for `a`
- a$enq__RDY  output  1  `a` FIFO not full
- b$enq__ENA  input  1  enqueue to input `b`; asserted only while b$enq__RDY=1
- b$enq$v  input  128  data for `b`
- b$enq__RDY  output  1  `b` FIFO not full
- out$enq__ENA  output  1  transfer to downstream this cycle
- out$enq$v  output  128  data transferred
- out$enq__RDY  input  1  downstream can accept
- grant_b  output  1  source of the current transfer (1 = `b`); valid when out$enq__ENA=1

## Operation
- State per input: storage array [DEPTH]x128, read pointer, write pointer, count (log2(DEPTH)+1 bits). Pointers wrap modulo DEPTH.
- Arbiter state: `prio_b`, 1 bit. It names the input that wins when both are non-empty.
- Request: req_a = (count_a≠0), req_b = (count_b≠0).
- Grant (combinational):
  - Only one request: that input wins.
  - Both request: winner = `b` if STRICT=1, else `prio_b`.
- Transfer: out$enq__ENA = out$enq__RDY & (req_a | req_b).
  - out$enq__ENA is never high while out$enq__RDY=0.
  - out$enq$v = head entry of the winner; 0 when out$enq__ENA=0.
  - grant_b = winner is `b`.
- On a transfer: dequeue from the winner. With STRICT=0, `prio_b` ← (winner is `a`). With no transfer, `prio_b` holds.
- Input side: x$enq__RDY = nRST & (count_x≠DEPTH). On x$enq__ENA, write x$enq$v at the write pointer and advance it.
- Simultaneous enqueue and dequeue on the same FIFO: count unchanged, both pointers advance.
  - A full FIFO deasserts RDY even if a dequeue occurs in the same cycle (no bypass).
  - An empty FIFO cannot forward the same-cycle enqueue to out (no bypass).
- Enqueue while RDY=0 is a protocol violation. Behaviour is undefined; the bench asserts it never happens.

## Timing
- Reset (nRST low, asynchronous): counts=0, pointers=0, `prio_b`=0 (`a` wins the first contention).
  - Outputs during reset: a$enq__RDY=0, b$enq__RDY=0, out$enq__ENA=0, out$enq$v=0, grant_b=0.
  - Storage contents are not reset.
- First cycle after nRST rises: both RDY=1.
- Latency: data enqueued at edge t appears on out$enq at the cycle after t (1 cycle) if that FIFO wins and out$enq__RDY=1.
- Throughput: one transfer per cycle. Under continuous contention with STRICT=0, grants alternate a,b,a,b…
- Backpressure: with out$enq__RDY=0, FIFOs fill. x$enq__RDY drops in the cycle after the DEPTH-th enqueue.
- Reset mid-operation: all buffered data is discarded and outputs are forced to reset values immediately. No partial transfer is reported after nRST falls.

## Test plan
- Reset and idle: nRST low then high, no traffic → out$enq__ENA=0, out$enq$v=0; both RDY=1 from the first post-reset cycle.
- Single source: enqueue a=0x11..11 at cycle 1 with out RDY=1 → cycle 2: out$enq__ENA=1, v=0x11..11, grant_b=0; FIFO `a` empty at cycle 3.
- Round-robin contention (STRICT=0): preload a={A0,A1}, b={B0,B1}, then raise out RDY → out sequence A0,B0,A1,B1; grant_b=0,1,0,1.
- Strict mode (STRICT=1): same preload → B0,B1,A0,A1.
- Full/backpressure: out RDY=0, enqueue 2 into `a` (DEPTH=2) → a$enq__RDY=0. Raise out RDY → a$enq__RDY=1 the cycle after the first dequeue. No data lost or duplicated.
- Mid-stream reset: assert nRST with both FIFOs holding 1 entry → outputs go to reset values immediately. After release, no stale data appears on out.
